// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the interval-timer master.
// Build option: TIMER_CTRL_SNAP_EN adds the snapshot read states.
package timer_ctrl_pkg;

`ifdef TIMER_CTRL_SNAP_EN
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_PL, ST_WR_PH, ST_WR_CTRL, ST_RUN, ST_CLR_ST, ST_WR_STOP,
    ST_SNAP_WR, ST_SNAP_RL, ST_SNAP_RH, ST_SNAP_CAP
  } state_t;
`else
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_PL, ST_WR_PH, ST_WR_CTRL, ST_RUN, ST_CLR_ST, ST_WR_STOP
  } state_t;
`endif

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  // A zero period would make the slave fire every cycle with no room to
  // acknowledge, so the smallest programmable period is 1.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs the interval timer, acknowledges each
// timeout and produces a tick pulse plus a wrapping tick count.
// Build option: TIMER_CTRL_SNAP_EN adds snap_req/snap_valid/snap_value.
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | timer not programmed, waiting for cfg_start
// WR_PL       | write period low half (addr 2)
// WR_PH       | write period high half (addr 3)
// WR_CTRL     | write CTRL_RUN to control (addr 1)
// RUN         | timer free-running, watching stop/start/irq
// CLR_ST      | write 0 to status, acknowledges irq, tick pulse
// WR_STOP     | write CTRL_STOP to control, then IDLE
// SNAP_WR     | write snap register to latch counter (option)
// SNAP_RL     | read snap low (option)
// SNAP_RH     | read snap high, capture low half (option)
// SNAP_CAP    | capture high half, snap_valid pulse (option)
module timer_ctrl_master
  import timer_ctrl_pkg::*;
#(
  parameter int         TICK_W    = 16,
  parameter logic [3:0] CTRL_RUN  = 4'h7,
  parameter logic [3:0] CTRL_STOP = 4'h8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_stop,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
`ifdef TIMER_CTRL_SNAP_EN
  ,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [31:0]       snap_value
`endif
);

  state_t            state, state_nxt;
  logic              load_period;
  logic [31:0]       period_q;
  logic [TICK_W-1:0] tick_count_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; stop beats restart beats irq (beats snapshot).
  always_comb begin
    state_nxt   = state;
    load_period = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          state_nxt   = ST_WR_PL;
          load_period = 1'b1;
        end
      end
      ST_WR_PL:   state_nxt = ST_WR_PH;
      ST_WR_PH:   state_nxt = ST_WR_CTRL;
      ST_WR_CTRL: state_nxt = ST_RUN;
      ST_RUN: begin
        if (cfg_stop) begin
          state_nxt = ST_WR_STOP;
        end else if (cfg_start) begin
          state_nxt   = ST_WR_PL;
          load_period = 1'b1;
        end else if (tmr_irq) begin
          state_nxt = ST_CLR_ST;
        end
`ifdef TIMER_CTRL_SNAP_EN
        else if (snap_req) begin
          state_nxt = ST_SNAP_WR;
        end
`endif
      end
      ST_CLR_ST:  state_nxt = ST_RUN;
      ST_WR_STOP: state_nxt = ST_IDLE;
`ifdef TIMER_CTRL_SNAP_EN
      ST_SNAP_WR:  state_nxt = ST_SNAP_RL;
      ST_SNAP_RL:  state_nxt = ST_SNAP_RH;
      ST_SNAP_RH:  state_nxt = ST_SNAP_CAP;
      ST_SNAP_CAP: state_nxt = ST_RUN;
`endif
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Period latch and serviced-timeout counter; both reset on every start.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q     <= 32'd0;
      tick_count_q <= '0;
    end else if (load_period) begin
      period_q     <= clamp_period(cfg_period);
      tick_count_q <= '0;
    end else if (state == ST_CLR_ST) begin
      tick_count_q <= tick_count_q + TICK_W'(1);
    end
  end

  // Bus signals decoded straight from the registered state.
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = ADDR_STATUS;
    tmr_writedata  = 16'h0000;
    case (state)
      ST_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIOD_L;
        tmr_writedata  = period_q[15:0];
      end
      ST_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIOD_H;
        tmr_writedata  = period_q[31:16];
      end
      ST_WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = {12'h000, CTRL_RUN};
      end
      ST_CLR_ST: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_STATUS;
      end
      ST_WR_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = {12'h000, CTRL_STOP};
      end
`ifdef TIMER_CTRL_SNAP_EN
      ST_SNAP_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_SNAP_L;
      end
      ST_SNAP_RL: begin
        tmr_chipselect = 1'b1;
        tmr_address    = ADDR_SNAP_L;
      end
      ST_SNAP_RH: begin
        tmr_chipselect = 1'b1;
        tmr_address    = ADDR_SNAP_H;
      end
`endif
      default: ;
    endcase
  end

  assign busy       = (state == ST_WR_PL) || (state == ST_WR_PH) || (state == ST_WR_CTRL);
  assign tick       = (state == ST_CLR_ST);
  assign tick_count = tick_count_q;

`ifdef TIMER_CTRL_SNAP_EN
  logic [15:0] snap_lo_q, snap_hi_q;

  assign running = (state == ST_RUN) || (state == ST_CLR_ST) || (state == ST_SNAP_WR) ||
                   (state == ST_SNAP_RL) || (state == ST_SNAP_RH) || (state == ST_SNAP_CAP);

  // Capture the two snapshot halves as the registered readdata arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_lo_q <= 16'h0000;
      snap_hi_q <= 16'h0000;
    end else begin
      if (state == ST_SNAP_RH)  snap_lo_q <= tmr_readdata;
      if (state == ST_SNAP_CAP) snap_hi_q <= tmr_readdata;
    end
  end

  // The high half is forwarded combinationally so value and valid coincide.
  assign snap_valid = (state == ST_SNAP_CAP);
  assign snap_value = (state == ST_SNAP_CAP) ? {tmr_readdata, snap_lo_q} : {snap_hi_q, snap_lo_q};
`else
  logic unused_readdata;
  assign unused_readdata = ^tmr_readdata;
  assign running = (state == ST_RUN) || (state == ST_CLR_ST);
`endif

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Self-checking bench for timer_ctrl_master with a behavioural timer slave.
module tb_timer_ctrl_master;
  import timer_ctrl_pkg::*;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start, cfg_stop;
  logic [31:0]   cfg_period;
  logic          busy, running, tick;
  logic [TW-1:0] tick_count;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect, tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic [15:0]   tmr_readdata = 16'h0;
  logic          tmr_irq;
`ifdef TIMER_CTRL_SNAP_EN
  logic          snap_req, snap_valid;
  logic [31:0]   snap_value;
`endif

  timer_ctrl_master #(.TICK_W(TW)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_period(cfg_period),
    .cfg_stop(cfg_stop), .busy(busy), .running(running), .tick(tick),
    .tick_count(tick_count), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
`ifdef TIMER_CTRL_SNAP_EN
    , .snap_req(snap_req), .snap_valid(snap_valid), .snap_value(snap_value)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural interval-timer slave.
  logic [15:0] s_pl = 16'h0, s_ph = 16'h0;
  logic [31:0] s_cnt = 32'h0, s_snap = 32'h0;
  logic        s_run = 1'b0, s_irq = 1'b0;
  wire         s_wr = tmr_chipselect && !tmr_write_n;
  assign tmr_irq = s_irq;

  always @(posedge clk) begin
    if (s_run) begin
      if (s_cnt == 32'd0) s_cnt <= {s_ph, s_pl};
      else                s_cnt <= s_cnt - 32'd1;
    end
    if (s_run && s_cnt == 32'd0)          s_irq <= 1'b1;
    else if (s_wr && tmr_address == 3'd0) s_irq <= 1'b0;
    if (s_wr) begin
      case (tmr_address)
        3'd2: s_pl <= tmr_writedata;
        3'd3: s_ph <= tmr_writedata;
        3'd1: begin
          if (tmr_writedata[2]) begin
            s_run <= 1'b1;
            s_cnt <= {s_ph, s_pl};
          end
          if (tmr_writedata[3]) s_run <= 1'b0;
        end
        3'd4: s_snap <= s_cnt;
        default: ;
      endcase
    end
    tmr_readdata <= (tmr_address == 3'd4) ? s_snap[15:0] :
                    (tmr_address == 3'd5) ? s_snap[31:16] : 16'h0;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    int          c;
  } wr_t;
  wr_t sb[$];

  task automatic push(input logic [2:0] a, input logic [15:0] d, input int c);
    wr_t e;
    e.a = a; e.d = d; e.c = c;
    sb.push_back(e);
  endtask

  // Monitor: non-status writes pop the scoreboard; status writes are ticks.
  int          gap_exp = 0;
  int          last_tick = -1;
  logic [TW-1:0] tick_exp = '0;
  logic        irq_chk_pend = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (irq_chk_pend) begin
        chk("irq_after_clr", tmr_irq, 1'b0);
        irq_chk_pend = 1'b0;
      end
      if (tmr_chipselect && !tmr_write_n) begin
        if (tmr_address == ADDR_STATUS) begin
          chk("st_data", tmr_writedata, 16'h0);
          chk("st_tick", tick, 1'b1);
          chk("st_count", tick_count, tick_exp);
          tick_exp = tick_exp + 1'b1;
          if (last_tick >= 0) chk("tick_gap", cyc - last_tick, gap_exp);
          last_tick    = cyc;
          irq_chk_pend = (gap_exp >= 3);
        end else if (sb.size() == 0) begin
          chk("wr_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", tmr_address, e.a);
          chk("wr_data", tmr_writedata, e.d);
          chk("wr_cycle", cyc, e.c);
          if (tmr_address == ADDR_PERIOD_L) begin
            tick_exp  = '0;
            last_tick = -1;
          end
        end
      end else if (tick) begin
        chk("tick_without_write", tmr_chipselect, 1'b1);
      end
    end
  end

  task automatic wait_to(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Issue a one-cycle command from a bus-idle cycle (IDLE or RUN).
  task automatic drive(input logic st, input logic sp, input logic [31:0] per,
                       input logic need_irq, input int gap, output int n);
    int guard = 0;
    @(negedge clk);
    while ((tmr_chipselect || (need_irq && !tmr_irq)) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drive_wait", guard < 200, 1'b1);
    n = cyc;
    if (st) gap_exp = gap;
    cfg_start  = st;
    cfg_stop   = sp;
    cfg_period = per;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
  endtask

  task automatic count_ticks(input int want, output int got);
    int guard = 0;
    got = 0;
    while (got < want && guard < 400) begin
      @(negedge clk);
      if (tick) got++;
      guard++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, t;
    reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_period = 32'h0;
`ifdef TIMER_CTRL_SNAP_EN
    snap_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_count", tick_count, 0);
    chk("rst_cs", tmr_chipselect, 1'b0);
    chk("rst_wn", tmr_write_n, 1'b1);
    chk("rst_addr", tmr_address, 0);
    chk("rst_wdata", tmr_writedata, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Programming sequence and latency.
    drive(1'b1, 1'b0, 32'h0001_86A0, 1'b0, 0, n);
    push(3'd2, 16'h86A0, n + 1); push(3'd3, 16'h0001, n + 2); push(3'd1, 16'h0007, n + 3);
    for (int k = 1; k <= 4; k++) begin
      wait_to(n + k);
      chk("seq_busy", busy, k <= 3);
      chk("seq_running", running, k == 4);
    end
`ifdef TIMER_CTRL_SNAP_EN
    @(negedge clk);
    m = cyc;
    snap_req = 1'b1;
    push(3'd4, 16'h0, m + 1);
    @(posedge clk); #1 snap_req = 1'b0;
    wait_to(m + 3);
    chk("snap_early", snap_valid, 1'b0);
    wait_to(m + 4);
    chk("snap_valid", snap_valid, 1'b1);
    chk("snap_value", snap_value, s_snap);
`endif
    drive(1'b0, 1'b1, 32'h0, 1'b0, 0, m);
    push(3'd1, 16'h0008, m + 1);
    wait_to(m + 2);
    chk("stop_running", running, 1'b0);
    chk("stop_busy", busy, 1'b0);
    chk("stop_cs", tmr_chipselect, 1'b0);

    // Period 9: ticks every 10 cycles, five within 55 cycles.
    drive(1'b1, 1'b0, 32'd9, 1'b0, 10, n);
    push(3'd2, 16'd9, n + 1); push(3'd3, 16'd0, n + 2); push(3'd1, 16'h0007, n + 3);
    wait_to(n + 58);
    chk("p9_count", tick_count, 5);

    // Stop, start and irq together: only the stop write happens.
    drive(1'b1, 1'b1, 32'h0, 1'b1, 10, m);
    push(3'd1, 16'h0008, m + 1);
    wait_to(m + 1);
    chk("prio_tick", tick, 1'b0);
    chk("prio_running", running, 1'b0);
    wait_to(m + 2);
    chk("prio_idle_busy", busy, 1'b0);
    chk("prio_idle_run", running, 1'b0);
    chk("prio_idle_cs", tmr_chipselect, 1'b0);
    for (int k = 3; k <= 5; k++) begin
      wait_to(m + k);
      chk("prio_no_ack", tmr_chipselect, 1'b0);
    end

    // Period 0 is clamped to 1.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 2, n);
    push(3'd2, 16'h0001, n + 1); push(3'd3, 16'h0000, n + 2); push(3'd1, 16'h0007, n + 3);
    wait_to(n + 12);
    drive(1'b0, 1'b1, 32'h0, 1'b0, 0, m);
    push(3'd1, 16'h0008, m + 1);

    // Period 1: tick_count wraps after 16 ticks; restart clears it.
    drive(1'b1, 1'b0, 32'd1, 1'b0, 2, n);
    push(3'd2, 16'h0001, n + 1); push(3'd3, 16'h0000, n + 2); push(3'd1, 16'h0007, n + 3);
    count_ticks(16, t);
    chk("wrap_ticks_seen", t, 16);
    @(negedge clk);
    chk("wrap_count", tick_count, 0);
    count_ticks(3, t);
    chk("pre_restart_ticks", t, 3);
    drive(1'b1, 1'b0, 32'd5, 1'b0, 6, n);
    push(3'd2, 16'h0005, n + 1); push(3'd3, 16'h0000, n + 2); push(3'd1, 16'h0007, n + 3);
    wait_to(n + 1);
    chk("restart_count", tick_count, 0);
    chk("restart_running", running, 1'b0);
    chk("restart_busy", busy, 1'b1);
    wait_to(n + 4);
    chk("restart_run_again", running, 1'b1);
    wait_to(n + 20);
    drive(1'b0, 1'b1, 32'h0, 1'b0, 0, m);
    push(3'd1, 16'h0008, m + 1);

    // Reset in the middle of the write sequence.
    drive(1'b1, 1'b0, 32'h55, 1'b0, 0, n);
    push(3'd2, 16'h0055, n + 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_cs", tmr_chipselect, 1'b0);
    chk("midrst_wn", tmr_write_n, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_running", running, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
